// File: rtl/s2p_frame_controller.sv
// s2p_frame_controller: two requesters share one 4-lane frame assembler.
// Round-robin grant in IDLE, the winner owns the frame until EMIT hands it off.
// Optional feature macro: S2P_TIMEOUT_FLUSH_EN (flush partial frame after TIMEOUT idle cycles).
module s2p_frame_controller #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_d0,
    output logic [DATA_W-1:0] out_d1,
    output logic [DATA_W-1:0] out_d2,
    output logic [DATA_W-1:0] out_d3,
    output logic [DATA_W-1:0] out_com,
    output logic              out_src,
    output logic [2:0]        out_count
);

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    state_t                  state_q, state_d;
    logic [3:0][DATA_W-1:0]  lane_q;
    logic [DATA_W-1:0]       com_q;
    logic [2:0]              count_q;
    logic                    owner_q;
    logic                    prio_q;

    logic                    gsel;
    logic                    owner_vld;
    logic                    accept;
    logic [DATA_W-1:0]       word;
    logic                    flush;

    // Contested IDLE grants follow the round-robin pointer; otherwise whoever is valid.
    assign gsel      = (req0_valid && req1_valid) ? prio_q : req1_valid;
    assign owner_vld = owner_q ? req1_valid : req0_valid;
    assign accept    = (req0_ready && req0_valid) || (req1_ready && req1_valid);
    assign word      = req1_ready ? req1_data : req0_data;

`ifdef S2P_TIMEOUT_FLUSH_EN
    logic [7:0] idle_q;

    // Flush fires on the idle cycle that brings the counter up to TIMEOUT.
    assign flush = (state_q == COLLECT) && !owner_vld && ((idle_q + 8'd1) == 8'(TIMEOUT));

    // Idle counter: counts owner-silent COLLECT cycles, cleared by any accept or on leaving.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idle_q <= '0;
        end else if (state_q != COLLECT || accept || flush) begin
            idle_q <= '0;
        end else if (!owner_vld) begin
            idle_q <= idle_q + 8'd1;
        end
    end
`else
    assign flush = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = COLLECT;
            COLLECT: if ((accept && count_q == 3'd3) || flush) state_d = EMIT;
            EMIT:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs; readies are forced low while reset is held.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        out_valid  = (state_q == EMIT);
        if (reset) begin
            case (state_q)
                IDLE: begin
                    req0_ready = req0_valid && !gsel;
                    req1_ready = req1_valid &&  gsel;
                end
                COLLECT: begin
                    req0_ready = !owner_q;
                    req1_ready =  owner_q;
                end
                default: ;
            endcase
        end
    end

    // Frame datapath: lane writes, running XOR, count, ownership and priority pointer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lane_q  <= '0;
            com_q   <= '0;
            count_q <= '0;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    lane_q[0] <= word;
                    com_q     <= word;
                    count_q   <= 3'd1;
                    owner_q   <= gsel;
                end
                COLLECT: if (accept) begin
                    lane_q[count_q[1:0]] <= word;
                    com_q                <= com_q ^ word;
                    count_q              <= count_q + 3'd1;
                end
                EMIT: if (out_ready) begin
                    lane_q  <= '0;
                    com_q   <= '0;
                    count_q <= '0;
                    prio_q  <= ~owner_q;
                end
                default: ;
            endcase
        end
    end

    assign out_d0    = lane_q[0];
    assign out_d1    = lane_q[1];
    assign out_d2    = lane_q[2];
    assign out_d3    = lane_q[3];
    assign out_com   = com_q;
    assign out_src   = owner_q;
    assign out_count = count_q;

endmodule
